// File: rtl/axi4_demux.sv
// axi4_demux: routes one upstream AXI4 master port to slot_num_p downstream
// slots. The slot is chosen by the address bits above slot_addr_width_p.
// Addresses beyond the last slot are answered locally with DECERR.
// Independent write and read FSMs allow one write and one read in flight.
//
// Bundle layouts, MSB first:
//   ax payload : {id, addr, len[7:0], size[2:0], burst[1:0], lock,
//                 cache[3:0], prot[2:0], qos[3:0], region[3:0]}
//   mosi       : {aw payload, awvalid, wdata, wstrb, wlast, wvalid, bready,
//                 ar payload, arvalid, rready}
//   miso       : {awready, wready, bid, bresp, bvalid,
//                 arready, rid, rdata, rresp, rlast, rvalid}
module axi4_demux #(
   parameter int slot_num_p        = 2,
   parameter int id_width_p        = 4,
   parameter int addr_width_p      = 32,
   parameter int data_width_p      = 32,
   parameter int slot_addr_width_p = 12,
   localparam int ax_width   = id_width_p + addr_width_p + 29,
   localparam int mosi_width = 2*ax_width + data_width_p + data_width_p/8 + 6,
   localparam int miso_width = 2*id_width_p + data_width_p + 10
) (
   input  logic                                   clk_i,
   input  logic                                   reset_i,
   input  logic [mosi_width-1:0]                  s_axi4_ser_i,
   output logic [miso_width-1:0]                  s_axi4_ser_o,
   output logic [slot_num_p-1:0][mosi_width-1:0]  m_axi4_par_o,
   input  logic [slot_num_p-1:0][miso_width-1:0]  m_axi4_par_i
);

   localparam int slot_width = (slot_num_p > 1) ? $clog2(slot_num_p) : 1;

   typedef enum logic [2:0] {
      W_IDLE, W_ADDR, W_DATA, W_RESP, W_ERR_DATA, W_ERR_RESP
   } wstate_t;

   typedef enum logic [1:0] {
      R_IDLE, R_ADDR, R_DATA, R_ERR
   } rstate_t;

   wstate_t w_state, w_next;
   rstate_t r_state, r_next;

   // upstream request fields
   logic [ax_width-1:0]       s_aw_pl, s_ar_pl;
   logic                      s_awvalid, s_arvalid;
   logic [data_width_p-1:0]   s_wdata;
   logic [data_width_p/8-1:0] s_wstrb;
   logic                      s_wlast, s_wvalid, s_bready, s_rready;

   // upstream response fields
   logic                      s_awready, s_wready, s_bvalid, s_arready;
   logic                      s_rvalid, s_rlast;
   logic [id_width_p-1:0]     s_bid, s_rid;
   logic [1:0]                s_bresp, s_rresp;
   logic [data_width_p-1:0]   s_rdata;

   // per-slot control toward the slots
   logic [slot_num_p-1:0]     m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;

   // per-slot responses from the slots
   logic [slot_num_p-1:0]     m_awready, m_wready, m_bvalid, m_arready;
   logic [slot_num_p-1:0]     m_rvalid, m_rlast;
   logic [id_width_p-1:0]     m_bid [slot_num_p];
   logic [id_width_p-1:0]     m_rid [slot_num_p];
   logic [1:0]                m_bresp [slot_num_p];
   logic [1:0]                m_rresp [slot_num_p];
   logic [data_width_p-1:0]   m_rdata [slot_num_p];

   // latched transaction state
   logic [ax_width-1:0]       aw_pl, ar_pl;
   logic [slot_width-1:0]     w_slot, r_slot;
   logic [7:0]                beat_cnt;

   // address decode
   logic [addr_width_p-1:0]   aw_index, ar_index;
   logic                      aw_err, ar_err;
   logic [id_width_p-1:0]     w_id, r_id;
   logic [7:0]                r_len;

   assign {s_aw_pl, s_awvalid, s_wdata, s_wstrb, s_wlast, s_wvalid, s_bready,
           s_ar_pl, s_arvalid, s_rready} = s_axi4_ser_i;

   assign s_axi4_ser_o = {s_awready, s_wready, s_bid, s_bresp, s_bvalid,
                          s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid};

   assign aw_index = s_aw_pl[ax_width-id_width_p-1 -: addr_width_p] >> slot_addr_width_p;
   assign ar_index = s_ar_pl[ax_width-id_width_p-1 -: addr_width_p] >> slot_addr_width_p;
   assign aw_err   = aw_index >= addr_width_p'(slot_num_p);
   assign ar_err   = ar_index >= addr_width_p'(slot_num_p);
   assign w_id     = aw_pl[ax_width-1 -: id_width_p];
   assign r_id     = ar_pl[ax_width-1 -: id_width_p];
   assign r_len    = ar_pl[28:21];

   // pack/unpack the per-slot bundles; latched AW/AR and live W payloads go to every slot
   always_comb begin
      for (int unsigned i = 0; i < unsigned'(slot_num_p); i++) begin
         m_axi4_par_o[i] = {aw_pl, m_awvalid[i], s_wdata, s_wstrb, s_wlast, m_wvalid[i],
                            m_bready[i], ar_pl, m_arvalid[i], m_rready[i]};
         {m_awready[i], m_wready[i], m_bid[i], m_bresp[i], m_bvalid[i],
          m_arready[i], m_rid[i], m_rdata[i], m_rresp[i], m_rlast[i],
          m_rvalid[i]} = m_axi4_par_i[i];
      end
   end

   // write FSM state register
   always_ff @(posedge clk_i) begin
      if (reset_i) w_state <= W_IDLE;
      else         w_state <= w_next;
   end

   // capture AW fields and target slot on the upstream AW handshake
   always_ff @(posedge clk_i) begin
      if (!reset_i && w_state == W_IDLE && s_awvalid) begin
         aw_pl  <= s_aw_pl;
         w_slot <= aw_index[slot_width-1:0];
      end
   end

   // write FSM next state and handshake steering; everything idles low under reset
   always_comb begin
      w_next    = w_state;
      s_awready = 1'b0;
      s_wready  = 1'b0;
      s_bvalid  = 1'b0;
      s_bid     = '0;
      s_bresp   = 2'b00;
      m_awvalid = '0;
      m_wvalid  = '0;
      m_bready  = '0;
      if (!reset_i) begin
         case (w_state)
            W_IDLE: begin
               s_awready = 1'b1;
               if (s_awvalid) w_next = aw_err ? W_ERR_DATA : W_ADDR;
            end
            W_ADDR: begin
               m_awvalid[w_slot] = 1'b1;
               if (m_awready[w_slot]) w_next = W_DATA;
            end
            W_DATA: begin
               m_wvalid[w_slot] = s_wvalid;
               s_wready         = m_wready[w_slot];
               if (s_wvalid && m_wready[w_slot] && s_wlast) w_next = W_RESP;
            end
            W_RESP: begin
               s_bvalid         = m_bvalid[w_slot];
               s_bid            = m_bid[w_slot];
               s_bresp          = m_bresp[w_slot];
               m_bready[w_slot] = s_bready;
               if (m_bvalid[w_slot] && s_bready) w_next = W_IDLE;
            end
            W_ERR_DATA: begin
               s_wready = 1'b1;
               if (s_wvalid && s_wlast) w_next = W_ERR_RESP;
            end
            W_ERR_RESP: begin
               s_bvalid = 1'b1;
               s_bid    = w_id;
               s_bresp  = 2'b11;
               if (s_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
         endcase
      end
   end

   // read FSM state register
   always_ff @(posedge clk_i) begin
      if (reset_i) r_state <= R_IDLE;
      else         r_state <= r_next;
   end

   // capture AR fields and target slot on the upstream AR handshake
   always_ff @(posedge clk_i) begin
      if (!reset_i && r_state == R_IDLE && s_arvalid) begin
         ar_pl  <= s_ar_pl;
         r_slot <= ar_index[slot_width-1:0];
      end
   end

   // error-beat counter: advances only when an error beat is accepted upstream
   always_ff @(posedge clk_i) begin
      if (reset_i || r_state == R_IDLE)     beat_cnt <= '0;
      else if (r_state == R_ERR && s_rready) beat_cnt <= beat_cnt + 8'd1;
   end

   // read FSM next state and handshake steering; everything idles low under reset
   always_comb begin
      r_next    = r_state;
      s_arready = 1'b0;
      s_rvalid  = 1'b0;
      s_rid     = '0;
      s_rdata   = '0;
      s_rresp   = 2'b00;
      s_rlast   = 1'b0;
      m_arvalid = '0;
      m_rready  = '0;
      if (!reset_i) begin
         case (r_state)
            R_IDLE: begin
               s_arready = 1'b1;
               if (s_arvalid) r_next = ar_err ? R_ERR : R_ADDR;
            end
            R_ADDR: begin
               m_arvalid[r_slot] = 1'b1;
               if (m_arready[r_slot]) r_next = R_DATA;
            end
            R_DATA: begin
               s_rvalid         = m_rvalid[r_slot];
               s_rid            = m_rid[r_slot];
               s_rdata          = m_rdata[r_slot];
               s_rresp          = m_rresp[r_slot];
               s_rlast          = m_rlast[r_slot];
               m_rready[r_slot] = s_rready;
               if (m_rvalid[r_slot] && s_rready && m_rlast[r_slot]) r_next = R_IDLE;
            end
            R_ERR: begin
               s_rvalid = 1'b1;
               s_rid    = r_id;
               s_rresp  = 2'b11;
               s_rlast  = (beat_cnt == r_len);
               if (s_rready && beat_cnt == r_len) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_demux.sv
// Directed bench for axi4_demux with two slots of 4 KiB each.
module tb_axi4_demux;

   localparam int NS   = 2;
   localparam int IDW  = 4;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int SAW  = 12;
   localparam int AXW  = IDW + AW + 29;
   localparam int MOSI = 2*AXW + DW + DW/8 + 6;
   localparam int MISO = 2*IDW + DW + 10;

   logic clk = 1'b0;
   logic reset_i;
   logic [MOSI-1:0] s_in;
   logic [MISO-1:0] s_out;
   logic [NS-1:0][MOSI-1:0] m_out;
   logic [NS-1:0][MISO-1:0] m_in;

   // upstream master drive
   logic [IDW-1:0] awid, arid;
   logic [AW-1:0]  awaddr, araddr;
   logic [7:0]     awlen, arlen;
   logic           awvalid, arvalid, wvalid, wlast, bready, rready;
   logic [DW-1:0]  wdata;

   // upstream responses
   logic           up_awready, up_wready, up_bvalid, up_arready, up_rvalid, up_rlast;
   logic [IDW-1:0] up_bid, up_rid;
   logic [1:0]     up_bresp, up_rresp;
   logic [DW-1:0]  up_rdata;

   // slot drive
   logic [NS-1:0]  sl_awready, sl_wready, sl_bvalid, sl_arready, sl_rvalid, sl_rlast;
   logic [IDW-1:0] sl_bid [NS];
   logic [IDW-1:0] sl_rid [NS];
   logic [1:0]     sl_bresp [NS];
   logic [1:0]     sl_rresp [NS];
   logic [DW-1:0]  sl_rdata [NS];

   // slot observations
   logic [AXW-1:0]  o_aw_pl [NS];
   logic [AXW-1:0]  o_ar_pl [NS];
   logic [DW-1:0]   o_wdata [NS];
   logic [DW/8-1:0] o_wstrb [NS];
   logic [NS-1:0]   o_awvalid, o_wlast, o_wvalid, o_bready, o_arvalid, o_rready;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   axi4_demux #(
      .slot_num_p(NS), .id_width_p(IDW), .addr_width_p(AW),
      .data_width_p(DW), .slot_addr_width_p(SAW)
   ) dut (
      .clk_i(clk), .reset_i(reset_i),
      .s_axi4_ser_i(s_in), .s_axi4_ser_o(s_out),
      .m_axi4_par_o(m_out), .m_axi4_par_i(m_in)
   );

   always_comb begin
      s_in = {awid, awaddr, awlen, 3'd2, 2'b01, 16'h0000, awvalid, wdata, 4'hF, wlast, wvalid,
              bready, arid, araddr, arlen, 3'd2, 2'b01, 16'h0000, arvalid, rready};
      {up_awready, up_wready, up_bid, up_bresp, up_bvalid, up_arready,
       up_rid, up_rdata, up_rresp, up_rlast, up_rvalid} = s_out;
      for (int i = 0; i < NS; i++) begin
         m_in[i] = {sl_awready[i], sl_wready[i], sl_bid[i], sl_bresp[i], sl_bvalid[i],
                    sl_arready[i], sl_rid[i], sl_rdata[i], sl_rresp[i], sl_rlast[i], sl_rvalid[i]};
         {o_aw_pl[i], o_awvalid[i], o_wdata[i], o_wstrb[i], o_wlast[i], o_wvalid[i],
          o_bready[i], o_ar_pl[i], o_arvalid[i], o_rready[i]} = m_out[i];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_all();
      awid = '0; arid = '0; awaddr = '0; araddr = '0; awlen = '0; arlen = '0;
      awvalid = 0; arvalid = 0; wvalid = 0; wlast = 0; bready = 0; rready = 0; wdata = '0;
      sl_awready = '0; sl_wready = '0; sl_bvalid = '0; sl_arready = '0;
      sl_rvalid = '0; sl_rlast = '0;
      for (int i = 0; i < NS; i++) begin
         sl_bid[i] = '0; sl_rid[i] = '0; sl_bresp[i] = '0; sl_rresp[i] = '0; sl_rdata[i] = '0;
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      step(); step();
      awvalid = 1; arvalid = 1; #1;
      total++;
      if ({up_awready, up_arready, up_wready, up_bvalid, up_rvalid} !== 5'b0)
         $display("FAIL rst_up_handshakes: got %b want 00000",
                  {up_awready, up_arready, up_wready, up_bvalid, up_rvalid});
      else passed++;
      total++;
      if ({o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready} !== 10'b0)
         $display("FAIL rst_slot_handshakes: got %b want 0", {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready});
      else passed++;
      awvalid = 0; arvalid = 0;
      step();
      reset_i = 1'b0; #1;
      total++;
      if ({up_awready, up_arready} !== 2'b11)
         $display("FAIL rst_release_ready: got %b want 11", {up_awready, up_arready});
      else passed++;
   endtask

   task automatic test_write_slot1();
      awid = 4'd3; awaddr = 32'h1010; awlen = 8'd3; awvalid = 1; #1;
      total++;
      if (up_awready !== 1'b1) $display("FAIL wr_awready: got %b want 1", up_awready); else passed++;
      step();
      awvalid = 0; sl_awready[1] = 1; #1;
      total++;
      if (o_awvalid !== 2'b10) $display("FAIL wr_aw_slot: got %b want 10", o_awvalid); else passed++;
      total++;
      if (o_aw_pl[1][64:21] !== {4'd3, 32'h1010, 8'd3})
         $display("FAIL wr_aw_fields: got %h want %h", o_aw_pl[1][64:21], {4'd3, 32'h1010, 8'd3});
      else passed++;
      step();
      sl_awready[1] = 0;
      // slot raises a stray B during the data phase; must not be forwarded
      sl_bvalid[1] = 1; sl_bid[1] = 4'd3; sl_bresp[1] = 2'b00; bready = 1;
      wvalid = 1; wdata = 32'hA0; wlast = 0; sl_wready[1] = 0; #1;
      total++;
      if ({up_wready, up_bvalid, o_bready} !== 4'b0000)
         $display("FAIL wr_stall_and_stray_b: got %b want 0000", {up_wready, up_bvalid, o_bready});
      else passed++;
      for (int b = 0; b < 4; b++) begin
         if (b > 0) step();
         wvalid = 1; wdata = 32'hA0 + b; wlast = (b == 3); sl_wready[1] = 1; #1;
         total++;
         if ({o_wvalid, up_wready, o_wdata[1], o_wlast[1]} !== {2'b10, 1'b1, 32'hA0 + b, b == 3})
            $display("FAIL wr_beat%0d: got %b %b %h %b want 10 1 %h %b",
                     b, o_wvalid, up_wready, o_wdata[1], o_wlast[1], 32'hA0 + b, b == 3);
         else passed++;
      end
      step();
      wvalid = 0; wlast = 0; sl_wready[1] = 0; #1;
      total++;
      if ({up_bvalid, up_bid, up_bresp, o_bready} !== {1'b1, 4'd3, 2'b00, 2'b10})
         $display("FAIL wr_bresp: got %b %h %b %b want 1 3 00 10", up_bvalid, up_bid, up_bresp, o_bready);
      else passed++;
      step();
      bready = 0; sl_bvalid[1] = 0; #1;
      total++;
      if ({up_awready, up_bvalid} !== 2'b10)
         $display("FAIL wr_idle: got %b want 10", {up_awready, up_bvalid});
      else passed++;
   endtask

   task automatic test_read_stall();
      arid = 4'd2; araddr = 32'h0040; arlen = 8'd0; arvalid = 1; #1;
      total++;
      if (up_arready !== 1'b1) $display("FAIL rd_arready: got %b want 1", up_arready); else passed++;
      step();
      arvalid = 0; sl_arready[0] = 1; #1;
      total++;
      if (o_arvalid !== 2'b01) $display("FAIL rd_ar_slot: got %b want 01", o_arvalid); else passed++;
      step();
      sl_arready[0] = 0;
      sl_rvalid[0] = 1; sl_rid[0] = 4'd2; sl_rdata[0] = 32'hDEADBEEF; sl_rlast[0] = 1;
      rready = 0;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) step();
         #1;
         total++;
         if ({up_rvalid, up_rdata, up_rid, up_rlast, o_rready} !== {1'b1, 32'hDEADBEEF, 4'd2, 1'b1, 2'b00})
            $display("FAIL rd_stall%0d: got %b %h %h %b %b want 1 deadbeef 2 1 00",
                     c, up_rvalid, up_rdata, up_rid, up_rlast, o_rready);
         else passed++;
      end
      step();
      rready = 1; #1;
      total++;
      if ({up_rvalid, up_rlast, o_rready} !== 4'b1101)
         $display("FAIL rd_accept: got %b want 1101", {up_rvalid, up_rlast, o_rready});
      else passed++;
      step();
      // slot0 still shows rvalid; back in idle it must be ignored
      #1;
      total++;
      if ({up_arready, up_rvalid, o_rready} !== 4'b1000)
         $display("FAIL rd_idle: got %b want 1000", {up_arready, up_rvalid, o_rready});
      else passed++;
      rready = 0; sl_rvalid[0] = 0; sl_rlast[0] = 0;
   endtask

   task automatic test_write_decerr();
      step();
      awid = 4'd5; awaddr = 32'h2000; awlen = 8'd1; awvalid = 1;
      step();
      awvalid = 0; wvalid = 1; wdata = 32'h55; wlast = 0; #1;
      total++;
      if ({o_awvalid, o_wvalid, up_wready} !== 5'b00001)
         $display("FAIL we_sink0: got %b want 00001", {o_awvalid, o_wvalid, up_wready});
      else passed++;
      step();
      wlast = 1; #1;
      total++;
      if ({up_wready, up_bvalid} !== 2'b10)
         $display("FAIL we_sink1: got %b want 10", {up_wready, up_bvalid});
      else passed++;
      step();
      wvalid = 0; wlast = 0; bready = 0;
      step();
      #1;
      total++;
      if ({up_bvalid, up_bid, up_bresp, up_wready} !== {1'b1, 4'd5, 2'b11, 1'b0})
         $display("FAIL we_bresp: got %b %h %b %b want 1 5 11 0", up_bvalid, up_bid, up_bresp, up_wready);
      else passed++;
      bready = 1;
      step();
      bready = 0; #1;
      total++;
      if ({up_awready, up_bvalid} !== 2'b10)
         $display("FAIL we_idle: got %b want 10", {up_awready, up_bvalid});
      else passed++;
   endtask

   task automatic test_read_decerr();
      logic [2:0] rr_pat;
      logic [2:0] last_pat;
      rr_pat = 3'b0; last_pat = 3'b0;
      arid = 4'd7; araddr = 32'h3000; arlen = 8'd2; arvalid = 1;
      step();
      arvalid = 0;
      // cycles: beat0 accepted, beat1 stalled, beat1 accepted, beat2 accepted
      for (int c = 0; c < 4; c++) begin
         if (c > 0) step();
         rready = (c != 1); #1;
         total++;
         if ({up_rvalid, up_rid, up_rdata, up_rresp, up_rlast, o_arvalid} !==
             {1'b1, 4'd7, 32'h0, 2'b11, c == 3, 2'b00})
            $display("FAIL re_beat_c%0d: got %b %h %h %b %b %b want 1 7 0 11 %b 00",
                     c, up_rvalid, up_rid, up_rdata, up_rresp, up_rlast, o_arvalid, c == 3);
         else passed++;
      end
      step();
      rready = 0; #1;
      total++;
      if ({up_arready, up_rvalid} !== 2'b10)
         $display("FAIL re_idle: got %b want 10", {up_arready, up_rvalid});
      else passed++;
   endtask

   task automatic test_concurrent();
      awid = 4'd9; awaddr = 32'h0100; awlen = 8'd0; awvalid = 1;
      arid = 4'd4; araddr = 32'h0200; arlen = 8'd1; arvalid = 1; #1;
      total++;
      if ({up_awready, up_arready} !== 2'b11)
         $display("FAIL cc_ready: got %b want 11", {up_awready, up_arready});
      else passed++;
      step();
      awvalid = 0; arvalid = 0; sl_awready[0] = 1; sl_arready[0] = 1; #1;
      total++;
      if ({o_awvalid, o_arvalid, o_aw_pl[0][64:61], o_ar_pl[0][64:61], o_ar_pl[0][60:29]} !==
          {2'b01, 2'b01, 4'd9, 4'd4, 32'h0200})
         $display("FAIL cc_addr: got %b %b %h %h %h want 01 01 9 4 200",
                  o_awvalid, o_arvalid, o_aw_pl[0][64:61], o_ar_pl[0][64:61], o_ar_pl[0][60:29]);
      else passed++;
      step();
      sl_awready[0] = 0; sl_arready[0] = 0;
      wvalid = 1; wdata = 32'h11111111; wlast = 1; sl_wready[0] = 1;
      sl_rvalid[0] = 1; sl_rid[0] = 4'd4; sl_rdata[0] = 32'h22222222; sl_rlast[0] = 0; rready = 1; #1;
      total++;
      if ({o_wdata[0], up_wready, up_rdata, up_rid, up_rlast} !== {32'h11111111, 1'b1, 32'h22222222, 4'd4, 1'b0})
         $display("FAIL cc_beat1: got %h %b %h %h %b want 11111111 1 22222222 4 0",
                  o_wdata[0], up_wready, up_rdata, up_rid, up_rlast);
      else passed++;
      step();
      wvalid = 0; wlast = 0; sl_wready[0] = 0;
      sl_bvalid[0] = 1; sl_bid[0] = 4'd9; sl_bresp[0] = 2'b00; bready = 1;
      sl_rdata[0] = 32'h33333333; sl_rlast[0] = 1; #1;
      total++;
      if ({up_bvalid, up_bid, up_rvalid, up_rid, up_rdata, up_rlast} !==
          {1'b1, 4'd9, 1'b1, 4'd4, 32'h33333333, 1'b1})
         $display("FAIL cc_beat2: got %b %h %b %h %h %b want 1 9 1 4 33333333 1",
                  up_bvalid, up_bid, up_rvalid, up_rid, up_rdata, up_rlast);
      else passed++;
      step();
      sl_bvalid[0] = 0; sl_rvalid[0] = 0; sl_rlast[0] = 0; bready = 0; rready = 0; #1;
      total++;
      if ({up_awready, up_arready} !== 2'b11)
         $display("FAIL cc_idle: got %b want 11", {up_awready, up_arready});
      else passed++;
   endtask

   task automatic test_reset_mid();
      awid = 4'd1; awaddr = 32'h1000; awlen = 8'd3; awvalid = 1;
      step();
      awvalid = 0; sl_awready[1] = 1;
      step();
      sl_awready[1] = 0; wvalid = 1; wdata = 32'hB0; wlast = 0; sl_wready[1] = 1;
      step();
      wdata = 32'hB1; reset_i = 1; #1;
      total++;
      if ({up_wready, o_wvalid, up_awready} !== 4'b0000)
         $display("FAIL rm_during: got %b want 0000", {up_wready, o_wvalid, up_awready});
      else passed++;
      step();
      reset_i = 0; wvalid = 0; sl_wready[1] = 0; #1;
      total++;
      if ({o_awvalid, o_wvalid, up_bvalid, up_wready, up_awready} !== 7'b0000001)
         $display("FAIL rm_after: got %b want 0000001", {o_awvalid, o_wvalid, up_bvalid, up_wready, up_awready});
      else passed++;
   endtask

   initial begin
      clear_all();
      reset_i = 1'b1;
      test_reset();
      test_write_slot1();
      test_read_stall();
      test_write_decerr();
      test_read_decerr();
      test_concurrent();
      test_reset_mid();
      step();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/axi4_demux.md
AXI4_DEMUX -- requirements
Module: axi4_demux

Interface
REQ-001 SHALL have parameter slot_num_p, default "inv": number of downstream master slots, 2..16.
REQ-002 SHALL have parameter id_width_p, default "inv": AXI4 ID width.
REQ-003 SHALL have parameter addr_width_p, default "inv": AXI4 address width.
REQ-004 SHALL have parameter data_width_p, default "inv": AXI4 data width.
REQ-005 SHALL have parameter slot_addr_width_p, default "inv": each slot spans 2^slot_addr_width_p bytes.
REQ-006 SHALL have port clk_i, input, 1: sole clock, all logic on rising edge.
REQ-007 SHALL have port reset_i, input, 1: synchronous active-high reset.
REQ-008 SHALL have port s_axi4_ser_i, input, bsg_axi4_mosi_bus_width(1,...): upstream master-to-slave bundle.
REQ-009 SHALL have port s_axi4_ser_o, output, bsg_axi4_miso_bus_width(1,...): upstream slave-to-master bundle.
REQ-010 SHALL have port m_axi4_par_o, output, [slot_num_p][mosi width]: per-slot downstream master-to-slave bundles.
REQ-011 SHALL have port m_axi4_par_i, input, [slot_num_p][miso width]: per-slot downstream slave-to-master bundles.

Function
REQ-012 SHALL decode slot = addr >> slot_addr_width_p; slot >= slot_num_p SHALL be a decode error (DECERR, resp 2'b11).
REQ-013 SHALL run independent write and read FSMs; a read and a write SHALL proceed concurrently, including to the same slot.
REQ-014 SHALL allow at most one write and one read transaction outstanding at a time.
REQ-015 Write FSM states SHALL be W_IDLE, W_ADDR, W_DATA, W_RESP, W_ERR_DATA, W_ERR_RESP.
REQ-016 In W_IDLE, s awready SHALL be 1; on awvalid&awready SHALL latch all AW fields and slot, then go to W_ADDR (valid slot) or W_ERR_DATA (DECERR).
REQ-017 In W_ADDR, SHALL drive awvalid to the latched slot only, with latched fields; on that slot's awready SHALL go to W_DATA (AW forwarded exactly 1 cycle after upstream accept at the earliest).
REQ-018 In W_DATA, SHALL pass wvalid/wdata/wstrb/wlast to the slot and wready back combinationally; on a wlast handshake SHALL go to W_RESP.
REQ-019 In W_RESP, SHALL pass the slot's bvalid/bid/bresp upstream and bready to the slot; on the B handshake SHALL return to W_IDLE.
REQ-020 In W_ERR_DATA, SHALL hold s wready=1 and discard beats until a wlast handshake, then go to W_ERR_RESP.
REQ-021 In W_ERR_RESP, SHALL drive bvalid=1, bid=latched awid, bresp=2'b11 until bready, then return to W_IDLE.
REQ-022 Read FSM states SHALL be R_IDLE, R_ADDR, R_DATA, R_ERR.
REQ-023 In R_IDLE, s arready SHALL be 1; on handshake SHALL latch AR fields and slot, then go to R_ADDR or R_ERR.
REQ-024 In R_ADDR, SHALL drive arvalid to the latched slot only; on that slot's arready SHALL go to R_DATA.
REQ-025 In R_DATA, SHALL pass rvalid/rid/rdata/rresp/rlast upstream and rready to the slot; on an rlast handshake SHALL return to R_IDLE.
REQ-026 In R_ERR, SHALL generate exactly arlen+1 beats: rvalid=1, rid=latched arid, rdata=0, rresp=2'b11, rlast on the final beat only; the beat counter SHALL advance only on rready, and the FSM SHALL return to R_IDLE after the last beat.
REQ-027 AW/AR/W payload fields SHALL be broadcast to all slots; every valid and ready to a non-selected slot SHALL be 0.
REQ-028 Upstream wready/bvalid/rvalid and downstream bready/rready SHALL be 0 in any state not listed above as driving them.
REQ-029 Downstream slot responses arriving outside the matching state SHALL be ignored (not forwarded, not acknowledged).

Reset
REQ-030 While reset_i=1, both FSMs SHALL go to IDLE, the beat counter SHALL clear, and all valid/ready outputs SHALL be 0.
REQ-031 In the first cycle after reset_i falls, s awready and s arready SHALL be 1.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction with no further upstream or downstream handshakes.

Verification
REQ-033 slot_num_p=2, slot_addr_width_p=12: write awaddr=0x1010, awlen=3 -> AW at slot1 only, 4 W beats forwarded, slot1 bresp=0 returned with the original bid.
REQ-034 Read araddr=0x0040, arlen=0 with slot0 rready stalled 3 cycles -> R data held stable upstream, one beat with rlast=1, FSM back in R_IDLE.
REQ-035 Write awaddr=0x2000, awlen=1, awid=5 -> no slot sees awvalid, 2 W beats sunk, bresp=2'b11, bid=5.
REQ-036 Read araddr=0x3000, arlen=2, arid=7 -> 3 beats with rdata=0, rresp=2'b11, rid=7, rlast only on beat 3.
REQ-037 Concurrent write to slot0 and read from slot0 in the same cycle -> both complete, with no cross-corruption of IDs or data.
REQ-038 reset_i asserted during W_DATA beat 2 of 4 -> all valids 0 the next cycle, awready=1 the cycle after reset_i falls.
